// File: rtl/multi_timer.sv
// multi_timer: NCH independent down-counting timers behind a small
// word-addressed register file, with per-channel interrupt masking.
module multi_timer #(
  parameter int NCH   = 2,
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:2]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  localparam logic [1:0] R_CTRL   = 2'b00;
  localparam logic [1:0] R_PRESET = 2'b01;
  localparam logic [1:0] R_COUNT  = 2'b10;
  localparam logic [1:0] R_STATUS = 2'b11;
  localparam logic [1:0] M_RELOAD = 2'b01;
  localparam logic [1:0] M_FREE   = 2'b10;

  state_t           state     [NCH];
  state_t           state_nx  [NCH];
  logic [3:0]       ctrl      [NCH];
  logic [3:0]       ctrl_nx   [NCH];
  logic [WIDTH-1:0] preset    [NCH];
  logic [WIDTH-1:0] preset_nx [NCH];
  logic [WIDTH-1:0] count     [NCH];
  logic [WIDTH-1:0] count_nx  [NCH];
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   pending_nx;
  logic [NCH-1:0]   hit;
  logic [NCH-1:0]   irq_vec;
  logic [1:0]       sel;

  assign sel = Addr[3:2];

  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++)
      hit[i] = (Addr[5:4] == 2'(i));
  end

  // A CTRL/PRESET write to a channel freezes its FSM for that cycle.
  always_comb begin
    pending_nx = pending;
    for (int i = 0; i < NCH; i++) begin
      state_nx[i]  = state[i];
      ctrl_nx[i]   = ctrl[i];
      preset_nx[i] = preset[i];
      count_nx[i]  = count[i];
      if (WE && hit[i] && sel == R_CTRL) begin
        ctrl_nx[i]    = Din[3:0];
        pending_nx[i] = 1'b0;
      end else if (WE && hit[i] && sel == R_PRESET) begin
        preset_nx[i] = Din[WIDTH-1:0];
        count_nx[i]  = Din[WIDTH-1:0];
      end else begin
        if (WE && sel == R_STATUS && |hit && Din[i])
          pending_nx[i] = 1'b0;
        unique case (state[i])
          IDLE: begin
            if (ctrl[i][0])
              state_nx[i] = LOAD;
          end
          LOAD: begin
            count_nx[i] = preset[i];
            state_nx[i] = CNT;
          end
          CNT: begin
            if (ctrl[i][0]) begin
              if (ctrl[i][2:1] == M_FREE) begin
                count_nx[i] = count[i] - WIDTH'(1);
              end else if (count[i] == '0) begin
                state_nx[i] = INT;
              end else begin
                count_nx[i] = count[i] - WIDTH'(1);
                if (count[i] == WIDTH'(1))
                  state_nx[i] = INT;
              end
            end
          end
          INT: begin
            pending_nx[i] = 1'b1;
            if (ctrl[i][2:1] == M_RELOAD) begin
              state_nx[i] = LOAD;
            end else begin
              ctrl_nx[i][0] = 1'b0;
              state_nx[i]   = IDLE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      for (int i = 0; i < NCH; i++) begin
        state[i]  <= IDLE;
        ctrl[i]   <= '0;
        preset[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      pending <= pending_nx;
      for (int i = 0; i < NCH; i++) begin
        state[i]  <= state_nx[i];
        ctrl[i]   <= ctrl_nx[i];
        preset[i] <= preset_nx[i];
        count[i]  <= count_nx[i];
      end
    end
  end

  always_comb begin
    Dout    = '0;
    irq_vec = '0;
    for (int i = 0; i < NCH; i++) begin
      irq_vec[i] = pending[i] & ctrl[i][3];
      if (hit[i]) begin
        case (sel)
          R_CTRL:   Dout = {28'd0, ctrl[i]};
          R_PRESET: Dout = 32'(preset[i]);
          R_COUNT:  Dout = 32'(count[i]);
          default:  Dout = 32'(pending);
        endcase
      end
    end
  end

  assign IRQ = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: random and directed register traffic against a
// behavioural timer model, checked through an expectation queue.
module tb_multi_timer;

  localparam int NCH = 2;
  localparam int W   = 8;
  localparam logic [31:0] MASK = 32'hFF;
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_CNT  = 2;
  localparam int P_INT  = 3;

  logic        clk;
  logic        reset;
  logic [5:2]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  logic [3:0]  m_ctrl [4];
  logic [31:0] m_pre  [4];
  logic [31:0] m_cnt  [4];
  bit          m_pend [4];
  int          m_ph   [4];

  multi_timer #(.NCH(NCH), .WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    else
      passed++;
  endtask

  function automatic logic [3:0] ad(int ch, int sel);
    return {2'(ch), 2'(sel)};
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      m_ctrl[c] = '0;
      m_pre[c]  = '0;
      m_cnt[c]  = '0;
      m_pend[c] = 0;
      m_ph[c]   = P_IDLE;
    end
  endfunction

  function automatic void model_step(bit we, logic [3:0] a, logic [31:0] d);
    int ch, sel, mode;
    bit own, setp, en;
    ch  = int'(a[3:2]);
    sel = int'(a[1:0]);
    for (int c = 0; c < NCH; c++) begin
      own  = we && ch == c;
      setp = 0;
      mode = int'(m_ctrl[c][2:1]);
      en   = m_ctrl[c][0];
      if (own && sel == 0) begin
        m_ctrl[c] = d[3:0];
        m_pend[c] = 0;
      end else if (own && sel == 1) begin
        m_pre[c] = d & MASK;
        m_cnt[c] = d & MASK;
      end else begin
        case (m_ph[c])
          P_IDLE: if (en) m_ph[c] = P_LOAD;
          P_LOAD: begin
            m_cnt[c] = m_pre[c];
            m_ph[c]  = P_CNT;
          end
          P_CNT: if (en) begin
            if (mode == 2) begin
              m_cnt[c] = (m_cnt[c] - 1) & MASK;
            end else if (m_cnt[c] <= 1) begin
              m_cnt[c] = 0;
              m_ph[c]  = P_INT;
            end else begin
              m_cnt[c] = m_cnt[c] - 1;
            end
          end
          default: begin
            setp = 1;
            if (mode == 1) begin
              m_ph[c] = P_LOAD;
            end else begin
              m_ctrl[c][0] = 1'b0;
              m_ph[c] = P_IDLE;
            end
          end
        endcase
        if (we && sel == 3 && ch < NCH && d[c]) m_pend[c] = 0;
        if (setp) m_pend[c] = 1;
      end
    end
  endfunction

  function automatic logic [31:0] exp_dout(logic [3:0] a);
    logic [31:0] st;
    int ch;
    ch = int'(a[3:2]);
    st = '0;
    for (int c = 0; c < NCH; c++) st[c] = m_pend[c];
    if (ch >= NCH) return '0;
    case (a[1:0])
      2'd0:    return {28'd0, m_ctrl[ch]};
      2'd1:    return m_pre[ch];
      2'd2:    return m_cnt[ch];
      default: return st;
    endcase
  endfunction

  function automatic logic exp_irq();
    logic r;
    r = 1'b0;
    for (int c = 0; c < NCH; c++) r = r | (m_pend[c] & m_ctrl[c][3]);
    return r;
  endfunction

  // Drive one cycle from posedge+1; the model advances at the edge.
  task automatic cycle(bit rst, bit we, logic [3:0] a, logic [31:0] d);
    exp_t e;
    reset = rst;
    WE    = we;
    Addr  = a;
    Din   = d;
    e.addr = a;
    e.dout = rst ? 32'd0 : exp_dout(a);
    e.irq  = rst ? 1'b0 : exp_irq();
    q.push_back(e);
    @(posedge clk);
    if (rst) model_reset();
    else model_step(we, a, d);
    #1;
  endtask

  task automatic wr(int ch, int sel, logic [31:0] d);
    cycle(0, 1, ad(ch, sel), d);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++)
      cycle(0, 0, 4'($urandom_range(0, 15)), $urandom);
  endtask

  task automatic rst_pulse();
    cycle(1, 0, ad(0, 0), 0);
  endtask

  task automatic peek(string nm, logic [3:0] a, logic [31:0] exp);
    WE   = 1'b0;
    Addr = a;
    #1;
    chk(nm, Dout, exp);
  endtask

  task automatic chk_irq(string nm, logic exp);
    chk(nm, 32'(IRQ), 32'(exp));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("dout@%h", e.addr), Dout, e.dout);
        chk("irq", 32'(IRQ), 32'(e.irq));
      end
    end
  end

  task automatic rand_phase(int n);
    int r, ch;
    logic [31:0] d;
    for (int k = 0; k < n; k++) begin
      r  = $urandom_range(0, 99);
      ch = $urandom_range(0, 3);
      d  = $urandom;
      if (r < 12)
        wr(ch, 0, d | 32'(r < 9));
      else if (r < 22)
        wr(ch, 1, (r < 20) ? ((d & 32'hFFFF_FF00) | $urandom_range(0, 9)) : d);
      else if (r < 30)
        wr(ch, 3, d);
      else if (r < 33)
        wr(ch, 2, d);
      else
        cycle(0, 0, ad(ch, $urandom_range(0, 3)), d);
    end
  endtask

  initial begin
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_pulse();
    peek("rst_ctrl", ad(0, 0), 0);
    chk_irq("rst_irq", 0);
    idle(2);
    peek("rst_cnt1", ad(1, 2), 0);

    // one-shot, PRESET=3: IRQ six edges after enabling
    wr(0, 1, 3);
    wr(0, 0, 32'h9);
    idle(5);
    chk_irq("os_irq_e5", 0);
    idle(1);
    chk_irq("os_irq_e6", 1);
    peek("os_ctrl", ad(0, 0), 32'h8);
    peek("os_cnt", ad(0, 2), 0);
    wr(1, 3, 1);
    chk_irq("os_clr", 0);

    // auto-reload, PRESET=2, period 4
    rst_pulse();
    wr(1, 1, 2);
    wr(1, 0, 32'hB);
    idle(4);
    chk_irq("ar_e4", 0);
    idle(1);
    chk_irq("ar_e5", 1);
    wr(0, 3, 2);
    chk_irq("ar_clr", 0);
    idle(2);
    chk_irq("ar_e8", 0);
    idle(1);
    chk_irq("ar_e9", 1);

    // PRESET=0 reaches INT without wrapping
    rst_pulse();
    wr(0, 1, 0);
    wr(0, 0, 1);
    idle(2);
    peek("z_cnt_e2", ad(0, 2), 0);
    idle(1);
    peek("z_st_e3", ad(0, 3), 0);
    idle(1);
    peek("z_st_e4", ad(1, 3), 1);
    idle(2);
    peek("z_cnt_e6", ad(0, 2), 0);

    // free-run wraps at WIDTH bits, never pending
    rst_pulse();
    wr(0, 1, 1);
    wr(0, 0, 32'h5);
    idle(2);
    peek("fr_1", ad(0, 2), 32'h01);
    idle(1);
    peek("fr_0", ad(0, 2), 32'h00);
    idle(1);
    peek("fr_ff", ad(0, 2), 32'hFF);
    idle(1);
    peek("fr_fe", ad(0, 2), 32'hFE);
    idle(10);
    peek("fr_st", ad(0, 3), 0);

    // pause at 6, resume at 5
    rst_pulse();
    wr(0, 1, 10);
    wr(0, 0, 1);
    idle(6);
    peek("pz_e6", ad(0, 2), 6);
    wr(0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      idle(1);
      peek("pz_hold", ad(0, 2), 6);
    end
    wr(0, 0, 1);
    peek("pz_re", ad(0, 2), 6);
    idle(1);
    peek("pz_5", ad(0, 2), 5);

    // asynchronous reset in the middle of a cycle
    rst_pulse();
    wr(0, 1, 50);
    wr(1, 1, 40);
    wr(0, 0, 32'h9);
    wr(1, 0, 32'hB);
    idle(8);
    WE   = 1'b0;
    Addr = ad(0, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_cnt0", Dout, 0);
    chk_irq("ar_irq", 0);
    Addr = ad(1, 2);
    #1;
    chk("ar_cnt1", Dout, 0);
    Addr = ad(1, 1);
    #1;
    chk("ar_pre1", Dout, 0);
    @(posedge clk);
    #1;
    model_reset();
    rst_pulse();
    idle(6);
    peek("post_cnt0", ad(0, 2), 0);
    peek("post_cnt1", ad(1, 2), 0);

    rst_pulse();
    rand_phase(3000);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter NCH, default 2: number of independent timer channels, legal range 1..4.
REQ-002 Parameter WIDTH, default 32: counter and preset width in bits, legal range 8..32.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-005 Addr  input  [5:2]  word address: Addr[5:4] = channel index, Addr[3:2] = register select.
REQ-006 WE  input  1  write strobe for the addressed register, sampled at the rising edge of clk.
REQ-007 Din  input  32  write data.
REQ-008 Dout  output  32  combinational read data for the addressed register.
REQ-009 IRQ  output  1  combinational OR over channels of (pending[i] AND CTRL[i].IM).

Function
REQ-010 Per-channel register map, selected by Addr[3:2]: 00 CTRL, 01 PRESET, 10 COUNT (read-only), 11 STATUS (global, identical for every channel index).
REQ-011 CTRL fields: bit0 EN, bits2:1 MODE, bit3 IM; bits 31:4 read 0 and ignore writes.
REQ-012 MODE encoding: 00 one-shot; 01 auto-reload; 10 free-run (counts down, wraps from 0 to all-ones, never interrupts); 11 behaves as 00.
REQ-013 PRESET and COUNT hold WIDTH bits and read zero-extended to 32 bits.
REQ-014 STATUS bits [NCH-1:0] = pending flags; remaining bits read 0; writing 1 to bit i clears pending[i]; writing 0 has no effect.
REQ-015 A channel index >= NCH reads 0, ignores writes, and leaves STATUS unaffected.
REQ-016 Each channel runs its own FSM with states IDLE, LOAD, CNT, INT.
REQ-017 IDLE: if EN=1, go to LOAD on the next edge.
REQ-018 LOAD: COUNT <= PRESET; go to CNT.
REQ-019 CNT with EN=1: COUNT <= COUNT-1; if COUNT==1 and MODE!=10, go to INT.
REQ-020 CNT with EN=1, COUNT==0 and MODE!=10 (PRESET==0 case): go to INT without decrementing; no wrap-around.
REQ-021 CNT with EN=0: COUNT frozen and state held; counting resumes when EN returns to 1.
REQ-022 INT: pending <= 1.
REQ-023 INT with MODE 00/11: clear EN and go to IDLE.
REQ-024 INT with MODE 01: go to LOAD.
REQ-025 Timing from PRESET=N>=1: the EN write is at edge 0 and pending is set at edge N+3.
REQ-026 A write to a channel's CTRL or PRESET has priority over that channel's FSM in that cycle; the FSM holds state for that cycle.
REQ-027 Other channels are unaffected by the write and advance normally.
REQ-028 Write to CTRL: load bits 3:0 and clear that channel's pending flag.
REQ-029 Write to PRESET: PRESET <= Din[WIDTH-1:0] and COUNT <= Din[WIDTH-1:0] in the same edge, in any state.
REQ-030 Write to COUNT: ignored.
REQ-031 Hardware setting pending and a STATUS write-1 clear on the same edge: the set wins.
REQ-032 Pending stays set until cleared by software, even when IM=0.

Reset
REQ-033 Reset forces CTRL, PRESET, COUNT and pending to 0 and every FSM to IDLE; Dout reflects the cleared registers and IRQ=0.
REQ-034 Reset asserted mid-count aborts the count immediately; after release every channel stays in IDLE until EN is written.

Verification
REQ-035 Ch0: PRESET=3, CTRL=0x9 (one-shot, IM) -> IRQ rises 6 edges after the CTRL write; CTRL reads 0x8; COUNT reads 0.
REQ-036 Ch1: PRESET=2, CTRL=0xB (auto-reload) -> pending set every 4 cycles; after a STATUS write of 0x2 clears it, IRQ reasserts 4 cycles later.
REQ-037 Ch0: PRESET=0, EN=1 -> INT reached 2 cycles after LOAD; COUNT stays 0 and never wraps to all-ones.
REQ-038 WIDTH=8, ch0 MODE=10, PRESET=1 -> COUNT sequence 1,0,0xFF,0xFE; pending never set.
REQ-039 Ch0 counting from 10, CTRL write with EN=0 at COUNT=6 -> COUNT holds 6 for 5 cycles; on re-enable, counting resumes at 5.
REQ-040 Assert reset asynchronously mid-count on both channels -> all reads 0 and IRQ=0 before the next clk edge.
